// File: rtl/sipo_pkg.sv
// Shared types for the framed SIPO receiver: FSM states, direction codes and
// the per-cycle control bundle handed to the shift core.
package sipo_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic DIR_MSB = 1'b1;
  localparam logic DIR_LSB = 1'b0;

  typedef struct packed {
    logic clr;
    logic en;
    logic dir;
    logic bit_in;
  } shift_ctl_t;
endpackage

// File: rtl/sipo_shift_core.sv
// WIDTH-bit shift register with clear-and-shift, shift-enable and direction.
// sr_nxt exposes the post-shift value so the controller can capture a word on its final bit.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  shift_ctl_t       ctl,
  output logic [WIDTH-1:0] sr_nxt
);
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;

  always_comb begin
    base   = ctl.clr ? '0 : sr;
    sr_nxt = base;
    if (ctl.en) begin
      if (ctl.dir == DIR_MSB) sr_nxt = {base[WIDTH-2:0], ctl.bit_in};
      else                    sr_nxt = {ctl.bit_in, base[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   sr <= '0;
    else if (ctl.en | ctl.clr) sr <= sr_nxt;
  end
endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: frame-start detection, bit counting, direction latch,
// holding register with valid/ready handshake, abort pulse and sticky overrun.
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_abort,
  output logic             overrun
);
  state_t           state, state_nxt;
  logic             dir_q;
  logic             start;
  logic             complete;
  logic             load;
  logic             drop;
  shift_ctl_t       ctl;
  logic [WIDTH-1:0] sr_nxt;

  // A frame_start always wins, including over the bit that would complete a word.
  assign start    = ser_valid & frame_start;
  assign complete = (state == SHIFT) & ser_valid & ~frame_start &
                    (bit_cnt == CNT_W'(WIDTH - 1));
  assign load     = complete & (~word_valid | word_ready);
  assign drop     = complete & word_valid & ~word_ready;
  assign busy     = (state == SHIFT);

  always_comb begin
    ctl.clr    = start;
    ctl.en     = (state == SHIFT) ? ser_valid : start;
    ctl.dir    = start ? msb_first : dir_q;
    ctl.bit_in = ser_in;
  end

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .ctl    (ctl),
    .sr_nxt (sr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)    state_nxt = SHIFT;
      SHIFT:   if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      dir_q       <= DIR_MSB;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= (state == SHIFT) & start;
      if (start) begin
        bit_cnt <= CNT_W'(1);
        dir_q   <= msb_first;
      end else if (complete) begin
        bit_cnt <= '0;
      end else if ((state == SHIFT) & ser_valid) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Holding register: a completing word replaces the held one only if it is being consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        word_out   <= sr_nxt;
        word_valid <= 1'b1;
      end else if (word_valid & word_ready) begin
        word_valid <= 1'b0;
      end
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl: expected words queued as frames are driven,
// popped and compared whenever the DUT hands a word over.
module tb_sipo_frame_ctrl;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst, ser_in, ser_valid, frame_start, msb_first, clr_overrun, word_ready;
  logic [W-1:0]  word_out;
  logic          word_valid, busy, frame_abort, overrun;
  logic [CW-1:0] bit_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic rdy_last = 1'b0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .msb_first(msb_first), .clr_overrun(clr_overrun),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .busy(busy), .bit_cnt(bit_cnt), .frame_abort(frame_abort), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with inputs set; inspects the handshake before the edge.
  task automatic cyc();
    if (word_valid && word_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", {24'h0, word_out}, 32'hDEAD);
      else                   chk("word_out", {24'h0, word_out}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [W-1:0] w, input logic msb, input int n);
    for (int i = 0; i < n; i++) begin
      ser_in      = msb ? w[W-1-i] : w[i];
      frame_start = (i == 0);
      msb_first   = msb;
      ser_valid   = 1'b1;
      cyc();
    end
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic msb, input int gap,
                            input logic push, input logic abort_exp);
    if (push) exp_q.push_back(w);
    for (int i = 0; i < W; i++) begin
      ser_in      = msb ? w[W-1-i] : w[i];
      frame_start = (i == 0);
      msb_first   = msb;
      ser_valid   = 1'b1;
      if (i == W - 1 && rdy_last) word_ready = 1'b1;
      cyc();
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      if (i == 0) chk("frame_abort_first", {31'h0, frame_abort}, {31'h0, abort_exp});
      if (i == 1) chk("frame_abort_clear", {31'h0, frame_abort}, 32'h0);
      if (i < W - 1) begin
        chk("bit_cnt", {28'h0, bit_cnt}, i + 1);
        chk("busy_mid", {31'h0, busy}, 32'h1);
        for (int g = 0; g < gap; g++) begin
          cyc();
          chk("bit_cnt_gap", {28'h0, bit_cnt}, i + 1);
        end
      end else begin
        chk("busy_done", {31'h0, busy}, 32'h0);
        chk("bit_cnt_done", {28'h0, bit_cnt}, 32'h0);
        if (push) chk("word_valid_done", {31'h0, word_valid}, 32'h1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
    msb_first = 1'b1; clr_overrun = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_word_out", {24'h0, word_out}, 32'h0);
    chk("rst_valid", {31'h0, word_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_bit_cnt", {28'h0, bit_cnt}, 32'h0);
    chk("rst_flags", {30'h0, frame_abort, overrun}, 32'h0);

    // ignored bits in IDLE
    ser_valid = 1'b1; ser_in = 1'b1; cyc(); ser_valid = 1'b0;
    chk("idle_ignore", {31'h0, busy}, 32'h0);

    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b0);
    cyc();
    chk("valid_one_cycle", {31'h0, word_valid}, 32'h0);
    send_frame(8'h03, 1'b0, 0, 1'b1, 1'b0);
    send_frame(8'hC0, 1'b1, 0, 1'b1, 1'b0);   // back-to-back
    cyc();
    send_frame(8'hA5, 1'b1, 2, 1'b1, 1'b0);   // gapped
    cyc();

    // overrun with a full holding register
    word_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
    chk("ovr_keep", {24'h0, word_out}, 32'h11);
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    cyc();
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);
    clr_overrun = 1'b1; cyc(); clr_overrun = 1'b0;
    chk("ovr_clr", {31'h0, overrun}, 32'h0);
    chk("held_valid", {31'h0, word_valid}, 32'h1);
    // consume and reload on the same edge
    rdy_last = 1'b1;
    send_frame(8'h44, 1'b0, 0, 1'b1, 1'b0);
    rdy_last = 1'b0;
    chk("swap_no_ovr", {31'h0, overrun}, 32'h0);
    chk("swap_word", {24'h0, word_out}, 32'h44);
    cyc();
    chk("swap_consumed", {31'h0, word_valid}, 32'h0);

    // restart after 5 bits, then restart on what would be the final bit
    send_bits(8'hFF, 1'b1, 5);
    send_frame(8'h96, 1'b1, 0, 1'b1, 1'b1);
    cyc();
    send_bits(8'hFF, 1'b1, 7);
    send_frame(8'h5C, 1'b0, 1, 1'b1, 1'b1);
    cyc();

    // reset mid-frame while a word is held
    word_ready = 1'b0;
    send_frame(8'h5A, 1'b1, 0, 1'b1, 1'b0);
    send_bits(8'h0F, 1'b1, 4);
    chk("pre_rst_cnt", {28'h0, bit_cnt}, 32'h4);
    rst = 1'b1; cyc(); rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_out", {24'h0, word_out}, 32'h0);
    chk("mid_rst_state", {28'h0, word_valid, busy, frame_abort, overrun}, 32'h0);
    chk("mid_rst_cnt", {28'h0, bit_cnt}, 32'h0);
    word_ready = 1'b1;
    send_frame(8'h3C, 1'b1, 0, 1'b1, 1'b0);
    cyc(); cyc();

    chk("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
